// File: rtl/ahfp_pkg.sv
// Shared constants for the ahfp datapath: element width, default pipeline
// latency (kept in one place so the result collector and pipeline buffer agree).
package ahfp_pkg;

    localparam int AHFP_WIDTH   = 32;
    localparam int AHFP_LATENCY = 10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ahfp_result_fifo_if.sv
// Issue / result handshake bundle between upstream issuer, pipeline output,
// the result collector and its consumer.
interface ahfp_result_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    import ahfp_pkg::*;

    logic                        issue_valid;
    logic                        issue_ready;
    logic [WIDTH-1:0]            pipe_out;
    logic [WIDTH-1:0]            res_data;
    logic                        res_valid;
    logic                        res_ready;
    logic [clog2(DEPTH+1)-1:0]   count;
    logic [clog2(DEPTH+1)-1:0]   inflight;
    logic                        overflow;

    modport slave (
        input  issue_valid, pipe_out, res_ready,
        output issue_ready, res_data, res_valid, count, inflight, overflow
    );

    modport master (
        output issue_valid, pipe_out, res_ready,
        input  issue_ready, res_data, res_valid, count, inflight, overflow
    );

endinterface

// File: rtl/ahfp_sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy counter disambiguates full/empty so
// pointers wrap naturally. Writes into a full FIFO without a pop are dropped.
module ahfp_sync_fifo
    import ahfp_pkg::*;
#(
    parameter int WIDTH = AHFP_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_wr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic [clog2(DEPTH+1)-1:0] o_count,
    output logic                      o_overflow
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);
    // A pop frees the slot at the read pointer this same edge, so a full FIFO can still take a write.
    assign w_wr   = i_wr && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata    = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/ahfp_result_fifo.sv
// Credit-controlled collector for a fixed-latency ahfp pipeline: tags valid
// slots, captures tagged results into a FIFO, and withholds issue credits.
module ahfp_result_fifo
    import ahfp_pkg::*;
#(
    parameter int LATENCY = AHFP_LATENCY,
    parameter int DEPTH   = 16,
    parameter int WIDTH   = AHFP_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    ahfp_result_fifo_if.slave  bus
);
    localparam int CW = clog2(DEPTH+1);

    logic [LATENCY-1:0] r_tag;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_used;
    logic               w_fire;
    logic               w_wr;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_rdata;

    // Credits count both queued and still-travelling results, so a non-stallable pipe never overruns.
    assign w_used          = {1'b0, w_count} + {1'b0, r_inflight};
    assign bus.issue_ready = (w_used < (CW+1)'(DEPTH));
    assign w_fire          = bus.issue_valid && bus.issue_ready;
    assign w_wr            = r_tag[LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag      <= '0;
            r_inflight <= '0;
        end else begin
            r_tag[0] <= w_fire;
            for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
            case ({w_fire, w_wr})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    ahfp_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (w_wr),
        .i_wdata    (bus.pipe_out),
        .i_pop      (bus.res_ready),
        .o_rdata    (w_rdata),
        .o_count    (w_count),
        .o_overflow (w_ovf)
    );

    assign bus.res_data  = w_rdata;
    assign bus.res_valid = (w_count != '0);
    assign bus.count     = w_count;
    assign bus.inflight  = r_inflight;
    assign bus.overflow  = w_ovf;

endmodule

// File: tb/tb_ahfp_result_fifo.sv
// Bench for ahfp_result_fifo: delay-line pipeline model upstream, scoreboard
// queue filled at issue and drained by an output monitor, plus directed checks.
module tb_ahfp_result_fifo;
    import ahfp_pkg::*;

    localparam int LAT   = 10;
    localparam int DEPTH = 16;
    localparam int W     = 32;
    localparam int CW    = clog2(DEPTH+1);

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;
    int   acc;
    logic [W-1:0] issue_data;
    logic [W-1:0] pipe [LAT];
    logic [W-1:0] sb_q [$];

    logic          u_wr;
    logic          u_pop;
    logic [W-1:0]  u_wdata;
    logic [W-1:0]  u_rdata;
    logic [CW-1:0] u_count;
    logic          u_ovf;

    ahfp_result_fifo_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

    ahfp_result_fifo #(.LATENCY(LAT), .DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Standalone FIFO instance to reach the full-FIFO corners the credit rule hides.
    ahfp_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_unit (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (u_wr),
        .i_wdata    (u_wdata),
        .i_pop      (u_pop),
        .o_rdata    (u_rdata),
        .o_count    (u_count),
        .o_overflow (u_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= issue_data;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pipe_out = pipe[LAT-1];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.issue_valid && bus.issue_ready) sb_q.push_back(issue_data);
    end

    always @(negedge clk) begin
        if (reset_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected actual=%h expected=none", bus.res_data);
            end else begin
                chk("sb_data", bus.res_data, sb_q.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 1'b0;
        bus.issue_valid = 1'b0; bus.res_ready = 1'b0; issue_data = '0;
        u_wr = 1'b0; u_pop = 1'b0; u_wdata = '0;

        // reset state
        mid();
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("rst_res_valid",   32'(bus.res_valid),   32'd0);
        chk("rst_count",       32'(bus.count),       32'd0);
        chk("rst_inflight",    32'(bus.inflight),    32'd0);
        chk("rst_overflow",    32'(bus.overflow),    32'd0);
        nxt(); nxt();
        reset_n = 1'b1;

        // single issue: output only in cycle 11
        bus.issue_valid = 1'b1; issue_data = 32'h3F80_0000; bus.res_ready = 1'b1;
        mid();
        chk("single_issue_ready", 32'(bus.issue_ready), 32'd1);
        nxt();
        bus.issue_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            mid();
            chk($sformatf("single_res_valid_c%0d", c), 32'(bus.res_valid), (c == 11) ? 32'd1 : 32'd0);
            chk($sformatf("single_inflight_c%0d", c), 32'(bus.inflight), (c <= 10) ? 32'd1 : 32'd0);
            nxt();
        end

        // continuous streaming, count sits at 1 with simultaneous write+pop
        for (int k = 0; k < 100; k++) begin
            bus.issue_valid = 1'b1; issue_data = 32'(k + 1);
            mid();
            chk("stream_issue_ready", 32'(bus.issue_ready), 32'd1);
            if (k >= 11) begin
                chk("stream_res_valid", 32'(bus.res_valid), 32'd1);
                chk("stream_count_1",   32'(bus.count),     32'd1);
            end
            nxt();
        end
        bus.issue_valid = 1'b0;
        for (int k = 0; k < 15; k++) nxt();
        mid();
        chk("stream_drained", 32'(bus.count), 32'd0);
        nxt();

        // fill with consumer stalled
        bus.res_ready = 1'b0; bus.issue_valid = 1'b1; acc = 0;
        for (int k = 0; k < 40; k++) begin
            issue_data = 32'h100 + 32'(k);
            mid();
            if (bus.issue_ready) acc++;
            nxt();
        end
        mid();
        chk("fill_accepted", 32'(acc),            32'd16);
        chk("fill_issue_rdy", 32'(bus.issue_ready), 32'd0);
        chk("fill_count",    32'(bus.count),      32'd16);
        chk("fill_inflight", 32'(bus.inflight),   32'd0);
        chk("fill_overflow", 32'(bus.overflow),   32'd0);
        nxt();

        // one-cycle pop from full frees exactly one credit
        acc = 0;
        for (int j = 0; j < 14; j++) begin
            bus.res_ready = (j == 0); issue_data = 32'h200 + 32'(j);
            mid();
            if (bus.issue_valid && bus.issue_ready) acc++;
            if (j == 0) chk("pulse_rdy_p0", 32'(bus.issue_ready), 32'd0);
            if (j == 1) chk("pulse_rdy_p1", 32'(bus.issue_ready), 32'd1);
            if (j == 2) begin
                chk("pulse_rdy_p2",      32'(bus.issue_ready), 32'd0);
                chk("pulse_inflight_p2", 32'(bus.inflight),    32'd1);
            end
            if (j == 11) chk("pulse_count_p11", 32'(bus.count), 32'd15);
            if (j == 12) chk("pulse_count_p12", 32'(bus.count), 32'd16);
            nxt();
        end
        chk("pulse_accepted", 32'(acc), 32'd1);

        // drain from full while issuing: count falls to 5 then holds across wraps
        for (int j = 0; j < 60; j++) begin
            bus.res_ready = 1'b1; bus.issue_valid = 1'b1; issue_data = 32'h300 + 32'(j);
            mid();
            if (j == 0) chk("wrap_count_q0", 32'(bus.count), 32'd16);
            if (j == 5) chk("wrap_count_q5", 32'(bus.count), 32'd11);
            if (j == 20) begin
                chk("wrap_count_q20",    32'(bus.count),    32'd5);
                chk("wrap_inflight_q20", 32'(bus.inflight), 32'd10);
            end
            if (j == 40) chk("wrap_count_q40", 32'(bus.count), 32'd5);
            nxt();
        end
        bus.issue_valid = 1'b0;
        for (int k = 0; k < 20; k++) nxt();
        mid();
        chk("wrap_drain_count",    32'(bus.count),     32'd0);
        chk("wrap_drain_inflight", 32'(bus.inflight),  32'd0);
        chk("wrap_drain_valid",    32'(bus.res_valid), 32'd0);
        chk("wrap_sb_empty",       32'(sb_q.size()),   32'd0);
        nxt();

        // reset with 3 queued and 5 in flight
        bus.res_ready = 1'b0;
        for (int j = 0; j < 13; j++) begin
            bus.issue_valid = (j < 3) || (j >= 8); issue_data = 32'h400 + 32'(j);
            nxt();
        end
        bus.issue_valid = 1'b0;
        mid();
        chk("prerst_count",    32'(bus.count),    32'd3);
        chk("prerst_inflight", 32'(bus.inflight), 32'd5);
        nxt();
        reset_n = 1'b0;
        sb_q.delete();
        mid();
        chk("midrst_count",       32'(bus.count),       32'd0);
        chk("midrst_inflight",    32'(bus.inflight),    32'd0);
        chk("midrst_res_valid",   32'(bus.res_valid),   32'd0);
        chk("midrst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("midrst_overflow",    32'(bus.overflow),    32'd0);
        nxt();
        reset_n = 1'b1; bus.res_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            mid();
            chk("postrst_no_capture", 32'(bus.res_valid), 32'd0);
            nxt();
        end

        // FIFO corners: write+pop while full, dropped write sets overflow
        for (int k = 0; k < 16; k++) begin
            u_wr = 1'b1; u_wdata = 32'hA0 + 32'(k);
            nxt();
        end
        u_wr = 1'b0;
        mid();
        chk("unit_full_count", 32'(u_count), 32'd16);
        chk("unit_full_head",  u_rdata,       32'hA0);
        chk("unit_full_ovf",   32'(u_ovf),    32'd0);
        nxt();
        u_wr = 1'b1; u_pop = 1'b1; u_wdata = 32'hB0;
        nxt();
        u_wr = 1'b0; u_pop = 1'b0;
        mid();
        chk("unit_wrpop_count", 32'(u_count), 32'd16);
        chk("unit_wrpop_head",  u_rdata,       32'hA1);
        chk("unit_wrpop_ovf",   32'(u_ovf),    32'd0);
        nxt();
        u_wr = 1'b1; u_wdata = 32'hC0;
        nxt();
        u_wr = 1'b0;
        mid();
        chk("unit_ovf_flag",  32'(u_ovf),    32'd1);
        chk("unit_ovf_count", 32'(u_count), 32'd16);
        nxt();
        for (int k = 0; k < 16; k++) begin
            u_pop = 1'b1;
            mid();
            chk($sformatf("unit_pop%0d", k), u_rdata, (k < 15) ? (32'hA1 + 32'(k)) : 32'hB0);
            nxt();
        end
        u_pop = 1'b0;
        mid();
        chk("unit_empty_count", 32'(u_count), 32'd0);
        chk("unit_ovf_sticky",  32'(u_ovf),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
